// File: rtl/axi_pkg.sv
// Shared AXI encodings and the line-reader state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2,
    RD_DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/axi_line_reader.sv
// AXI4 read master fetching one instruction-cache line per request as a single INCR burst.
// Optional AXI_RRESP_CHECK_EN adds a sticky rd_err flag for bad responses / short bursts.
module axi_line_reader
  import axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int ID_W       = 4,
  parameter int AR_ID      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         gnt,
  output logic [DATA_W*LINE_WORDS-1:0] line_data,
  output logic [ID_W-1:0]              arid,
  output logic [ADDR_W-1:0]            araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [ID_W-1:0]              rid,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic                         rd_err
);

  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int OFFS_W = $clog2(LINE_WORDS * 4);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  rd_state_e         state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] line_r [LINE_WORDS];
  logic              beat_s;
  logic              unused_s;

  assign beat_s   = (state_r == RD_R) && rvalid && rready;
  assign unused_s = ^{rid, rresp, rd_addr[OFFS_W-1:0]};

  assign arid    = ID_W'(AR_ID);
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  // Request sequencing: one AR handshake, then beats until rlast or a full line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RD_IDLE;
      gnt     <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      araddr  <= {ADDR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        RD_IDLE: begin
          gnt <= 1'b0;
          if (rd_req) begin
            araddr  <= {rd_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
            arvalid <= 1'b1;
            state_r <= RD_AR;
          end else begin
            state_r <= RD_IDLE;
          end
        end
        RD_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= RD_R;
          end else begin
            state_r <= RD_AR;
          end
        end
        RD_R: begin
          if (beat_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
            // A full line ends the burst even if the slave never raises rlast.
            if (rlast || (cnt_r == LAST_CNT)) begin
              rready  <= 1'b0;
              gnt     <= 1'b1;
              state_r <= RD_DONE;
            end else begin
              state_r <= RD_R;
            end
          end else begin
            state_r <= RD_R;
          end
        end
        RD_DONE: begin
          gnt     <= 1'b0;
          state_r <= RD_IDLE;
        end
        default: begin
          gnt     <= 1'b0;
          arvalid <= 1'b0;
          rready  <= 1'b0;
          state_r <= RD_IDLE;
        end
      endcase
    end
  end

  // Line buffer capture; deliberately not reset, words not written keep old data.
  always_ff @(posedge clk) begin
    if (!rst && beat_s) begin
      line_r[cnt_r] <= rdata;
    end else begin
      line_r[cnt_r] <= line_r[cnt_r];
    end
  end

  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_line
    assign line_data[i*DATA_W +: DATA_W] = line_r[i];
  end

`ifdef AXI_RRESP_CHECK_EN
  // Sticky error on any non-OKAY beat or a burst cut short by rlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err <= 1'b0;
    end else if (beat_s && ((rresp != AXI_RESP_OKAY) || (rlast && (cnt_r != LAST_CNT)))) begin
      rd_err <= 1'b1;
    end else begin
      rd_err <= rd_err;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_line_reader.sv
// Directed bench for axi_line_reader with a cycle-stepped AXI slave driven from the main sequence.
module tb_axi_line_reader;
  import axi_pkg::*;

`ifdef AXI_RRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_req = 1'b0;
  logic [31:0]  rd_addr = 32'h0;
  logic         gnt;
  logic [255:0] line_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [3:0]   rid = 4'h0;
  logic [31:0]  rdata = 32'h0;
  logic [1:0]   rresp = 2'b00;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic         rd_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_line [8];
  int gc;

  axi_line_reader dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .gnt(gnt),
    .line_data(line_data), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_word%0d", tag, k), line_data[k*32 +: 32], exp_line[k]);
  endtask

  // One refill: slave reacts at each negedge; gnt cycle counted in posedges after the request.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input int ar_wait, input bit gaps, input int last_beat,
                         input int err_beat, input int rst_beat, input logic [31:0] base,
                         output int gnt_cyc);
    int cyc = 0, beat = 0, ar_hi = 0, pulses = 0;
    bit toggle = 1'b0, addr_bad = 1'b0, fin = 1'b0, in_rst = 1'b0;
    gnt_cyc = -1;
    @(negedge clk);
    rd_req = 1'b1;
    rd_addr = addr;
    while (!fin && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (in_rst) begin
        chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
        chk("rst_rready", {31'b0, rready}, 32'd0);
        chk("rst_gnt", {31'b0, gnt}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        fin = 1'b1;
      end else if (gnt) begin
        pulses++;
        gnt_cyc = cyc;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        chk("gnt_one_cycle", {31'b0, gnt}, 32'd0);
        fin = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'h0;
        if (arvalid) begin
          if (araddr !== exp_addr || arlen !== 8'd7 || arsize !== 3'b010 ||
              arburst !== 2'b01 || arid !== 4'h0)
            addr_bad = 1'b1;
          ar_hi++;
          if (ar_hi > ar_wait) arready = 1'b1;
          rd_addr = addr ^ 32'hFFFF_0000;
        end else if (rready) begin
          toggle = !toggle;
          if (!gaps || toggle) begin
            rvalid = 1'b1;
            rdata  = base + beat;
            rlast  = (beat == last_beat);
            rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
            if (beat == rst_beat) begin
              rst = 1'b1;
              in_rst = 1'b1;
            end else begin
              exp_line[beat] = rdata;
            end
            beat++;
          end
        end
      end
    end
    chk("bounded_finish", {31'b0, fin}, 32'd1);
    if (in_rst) begin
      @(negedge clk);
      rst = 1'b0; rd_req = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    end else begin
      chk("gnt_pulses", pulses, 32'd1);
      chk("ar_valid_cycles", ar_hi, ar_wait + 1);
      chk("ar_fields_stable", {31'b0, addr_bad}, 32'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) exp_line[k] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_gnt", {31'b0, gnt}, 32'd0);
    chk("reset_arvalid", {31'b0, arvalid}, 32'd0);
    chk("reset_rready", {31'b0, rready}, 32'd0);
    chk("reset_rd_err", {31'b0, rd_err}, 32'd0);
    chk("reset_araddr", araddr, 32'd0);

    // 1: zero-wait slave, misaligned address
    run_txn(32'h1FC0_0044, 32'h1FC0_0040, 0, 1'b0, 7, -1, -1, 32'hA100_0000, gc);
    chk("t1_latency", gc, 32'd10);
    chk("t1_araddr", araddr, 32'h1FC0_0040);
    chk("t1_word0", line_data[31:0], 32'hA100_0000);
    chk("t1_word7", line_data[255:224], 32'hA100_0007);
    chk_line("t1");

    // 2: arready held off five cycles, rd_addr disturbed while busy
    run_txn(32'h0000_1238, 32'h0000_1220, 5, 1'b0, 7, -1, -1, 32'hA200_0000, gc);
    chk("t2_latency", gc, 32'd15);
    chk_line("t2");

    // 3: rvalid every other cycle
    run_txn(32'h8000_00E0, 32'h8000_00E0, 0, 1'b1, 7, -1, -1, 32'hA300_0000, gc);
    chk("t3_latency", gc, 32'd17);
    chk_line("t3");

    // 4: early rlast on beat 4, words 5..7 keep test-3 data
    run_txn(32'h0000_0400, 32'h0000_0400, 0, 1'b0, 4, -1, -1, 32'hA400_0000, gc);
    chk("t4_latency", gc, 32'd7);
    chk("t4_word5_kept", line_data[191:160], 32'hA300_0005);
    chk_line("t4");
    chk("t4_rd_err", {31'b0, rd_err}, {31'b0, EXP_ERR});

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_clears_rd_err", {31'b0, rd_err}, 32'd0);

    // 5: SLVERR on beat 2
    run_txn(32'h0000_0800, 32'h0000_0800, 0, 1'b0, 7, 2, -1, 32'hA500_0000, gc);
    chk("t5_latency", gc, 32'd10);
    chk("t5_word2", line_data[95:64], 32'hA500_0002);
    chk_line("t5");
    chk("t5_rd_err", {31'b0, rd_err}, {31'b0, EXP_ERR});

    // 6: reset during beat 3, then a clean refill
    run_txn(32'h0000_0C00, 32'h0000_0C00, 0, 1'b0, 7, -1, 3, 32'hA600_0000, gc);
    run_txn(32'h0000_1000, 32'h0000_1000, 0, 1'b0, 7, -1, -1, 32'hA700_0000, gc);
    chk("t6_latency", gc, 32'd10);
    chk_line("t6");
    chk("t6_rd_err", {31'b0, rd_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
